// File: rtl/ctrl_sequencer_if.sv
// Bundle of sequencer-side buses: instruction fetch, register-file ports, ALU operands and status.
// master = sequencer, slave = instruction memory / register file / ALU environment.
interface ctrl_sequencer_if #(
  parameter int PC_W = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid;
  logic [8:0]        imem_data;
  logic [1:0]        rf_rd0_addr;
  logic [1:0]        rf_rd1_addr;
  logic signed [8:0] rf_rd0_data;
  logic signed [8:0] rf_rd1_data;
  logic              rf_wr_en;
  logic [1:0]        rf_wr_addr;
  logic signed [8:0] rf_wr_data;
  logic [1:0]        alu_op;
  logic signed [8:0] alu_a;
  logic signed [8:0] alu_b;
  logic signed [8:0] alu_result;
  logic              halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    output rf_rd0_addr, rf_rd1_addr,
    input  rf_rd0_data, rf_rd1_data,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    input  rf_rd0_addr, rf_rd1_addr,
    output rf_rd0_data, rf_rd1_data,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  halted
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle sequencer: fetch, decode, execute via external ALU, write back to a 4x9 register file.
// Latency with no fetch wait: ALU op 4, LI 3, BEQZ 3, NOP 2 cycles; HALT parks until reset.
// Fetch stalls indefinitely while imem_valid is low; reset gates every strobe in its own cycle.
module ctrl_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_sequencer_if.master     bus
);

  localparam logic [2:0] OP_LI   = 3'b100;
  localparam logic [2:0] OP_BEQZ = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [8:0]        ir;
  logic signed [8:0] a_reg, b_reg, result;

  logic [2:0]        op;
  logic [1:0]        rd, rs, rt;
  logic signed [8:0] imm9;
  logic [PC_W-1:0]   imm_pc;

  assign op     = ir[8:6];
  assign rd     = ir[5:4];
  assign rs     = ir[3:2];
  assign rt     = ir[1:0];
  assign imm9   = {{5{ir[3]}}, ir[3:0]};
  assign imm_pc = {{(PC_W-4){ir[3]}}, ir[3:0]};

  // Operand routing is purely a function of the latched instruction.
  assign bus.imem_addr   = pc;
  assign bus.rf_rd0_addr = (op == OP_BEQZ) ? rd : rs;
  assign bus.rf_rd1_addr = rt;
  assign bus.rf_wr_addr  = rd;
  assign bus.rf_wr_data  = (op == OP_LI) ? imm9 : result;
  assign bus.alu_op      = op[1:0];
  assign bus.alu_a       = a_reg;
  assign bus.alu_b       = b_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state and strobes; rst masks strobes so a reset during WRITEBACK never commits.
  always_comb begin
    state_nxt    = state;
    bus.imem_req = 1'b0;
    bus.rf_wr_en = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req = !rst;
        if (bus.imem_valid) state_nxt = DECODE;
      end
      DECODE: begin
        case (op)
          OP_LI:   state_nxt = WRITEBACK;
          OP_NOP:  state_nxt = FETCH;
          OP_HALT: state_nxt = HALT;
          default: state_nxt = EXECUTE;
        endcase
      end
      EXECUTE: begin
        state_nxt = (op == OP_BEQZ) ? FETCH : WRITEBACK;
      end
      WRITEBACK: begin
        bus.rf_wr_en = !rst;
        state_nxt    = FETCH;
      end
      HALT: begin
        bus.halted = !rst;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Datapath registers: PC, instruction, latched operands and ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_valid) begin
            ir <= bus.imem_data;
            pc <= pc + PC_W'(1);
          end
        end
        DECODE: begin
          a_reg <= bus.rf_rd0_data;
          b_reg <= bus.rf_rd1_data;
        end
        EXECUTE: begin
          // pc already points past the branch, so the target is branch_addr + 1 + imm4.
          if (op == OP_BEQZ) begin
            if (a_reg == '0) pc <= pc + imm_pc;
          end else begin
            result <= bus.alu_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with register-file/ALU environment and write scoreboard.
module tb_ctrl_sequencer;
  localparam int         PC_W   = 8;
  localparam logic [7:0] RST_PC = 8'd240;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_sequencer_if #(.PC_W(PC_W)) bus ();
  ctrl_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Environment: register file and combinational ALU.
  logic [8:0] rf [4];
  assign bus.rf_rd0_data = rf[bus.rf_rd0_addr];
  assign bus.rf_rd1_data = rf[bus.rf_rd1_addr];
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      2'b00: bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01: bus.alu_result = bus.alu_a - bus.alu_b;
      2'b10: bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
  end
  always @(posedge clk) if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;

  typedef struct {
    logic [1:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         wr_cyc[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         wr_count = 0;
  bit         mon_en = 1'b1;
  logic [8:0] mdl [4];
  logic [7:0] mpc;
  logic [8:0] last_ins = '0;

  function automatic logic [8:0] sx9(input logic [3:0] v);
    return {{5{v[3]}}, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and score any write strobe.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en && bus.rf_wr_en) begin
      wr_count++;
      wr_cyc.push_back(cyc + 1);
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {30'b0, bus.rf_wr_addr}, {30'b0, e.addr});
        chk("wr_data", {23'b0, bus.rf_wr_data}, {23'b0, e.data});
      end
    end
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!bus.imem_req && n < 30) begin
      tick();
      n++;
    end
    chk("fetch_reached", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_wr_en", {31'b0, bus.rf_wr_en}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_addr", {24'b0, bus.imem_addr}, {24'b0, RST_PC});
    chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
    mpc = RST_PC;
    cyc = 0;
    last_ins = '0;
  endtask

  // Fetch one instruction (after `stall` idle fetch cycles) and book its expected effect.
  task automatic issue(input logic [8:0] ins, input int stall);
    logic [2:0] op;
    logic [1:0] rd, rs, rt;
    logic [8:0] res;
    op = ins[8:6]; rd = ins[5:4]; rs = ins[3:2]; rt = ins[1:0];
    wait_fetch();
    chk("fetch_addr", {24'b0, bus.imem_addr}, {24'b0, mpc});
    for (int i = 0; i < stall; i++) begin
      bus.imem_valid = 1'b0;
      tick();
      chk("stall_req", {31'b0, bus.imem_req}, 32'd1);
      chk("stall_addr", {24'b0, bus.imem_addr}, {24'b0, mpc});
      chk("stall_ir", {30'b0, bus.rf_rd1_addr}, {30'b0, last_ins[1:0]});
    end
    res = '0;
    case (op)
      3'b000: res = mdl[rs] + mdl[rt];
      3'b001: res = mdl[rs] - mdl[rt];
      3'b010: res = mdl[rs] & mdl[rt];
      3'b011: res = mdl[rs] | mdl[rt];
      3'b100: res = sx9(ins[3:0]);
      default: res = '0;
    endcase
    if (op <= 3'b100) begin
      exp_q.push_back('{addr: rd, data: res});
      mdl[rd] = res;
    end
    bus.imem_valid = 1'b1;
    bus.imem_data  = ins;
    tick();
    bus.imem_valid = 1'b0;
    last_ins = ins;
    mpc = mpc + 8'd1;
    if (op[2] == 1'b0) chk("alu_op", {30'b0, bus.alu_op}, {30'b0, op[1:0]});
    if (op == 3'b101 && mdl[rd] == 9'd0) mpc = mpc + {{4{ins[3]}}, ins[3:0]};
  endtask

  localparam logic [8:0] NOP  = 9'b110_00_0000;
  localparam logic [8:0] HALT = 9'b111_00_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    for (int i = 0; i < 4; i++) rf[i] = '0;

    // Reset and back-to-back LI/LI/ADD with cycle-exact write timing.
    do_reset();
    wr_count = 0;
    wr_cyc.delete();
    issue(9'b100_01_0011, 0);   // LI R1,3
    issue(9'b100_10_1110, 0);   // LI R2,-2
    issue(9'b000_11_01_10, 0);  // ADD R3,R1,R2
    wait_fetch();
    chk("t1_wr_count", 32'(wr_count), 32'd3);
    chk("t1_wr_cyc0", 32'(wr_cyc[0]), 32'd3);
    chk("t1_wr_cyc1", 32'(wr_cyc[1]), 32'd6);
    chk("t1_wr_cyc2", 32'(wr_cyc[2]), 32'd10);
    chk("t1_r2", {23'b0, rf[2]}, 32'h1FE);
    chk("t1_r3", {23'b0, rf[3]}, 32'h001);

    // SUB and OR of equal operands.
    issue(9'b100_00_0111, 0);   // LI R0,7
    issue(9'b100_01_0111, 0);   // LI R1,7
    issue(9'b001_10_00_01, 0);  // SUB R2,R0,R1
    issue(9'b011_11_00_01, 0);  // OR R3,R0,R1
    wait_fetch();
    chk("t2_r2", {23'b0, rf[2]}, 32'h000);
    chk("t2_r3", {23'b0, rf[3]}, 32'h007);

    // Five-cycle fetch stall, then normal completion.
    issue(9'b100_00_1000, 5);   // LI R0,-8
    wait_fetch();
    chk("t3_r0", {23'b0, rf[0]}, 32'h1F8);

    // Taken BEQZ at pc 254 wraps to 2, then a negative offset back to 255.
    while (mpc != 8'd254) issue(NOP, 0);
    issue(9'b101_10_0011, 0);   // BEQZ R2,+3
    wait_fetch();
    chk("beqz_wrap", {24'b0, bus.imem_addr}, 32'd2);
    issue(9'b101_10_1100, 0);   // BEQZ R2,-4
    wait_fetch();
    chk("beqz_neg", {24'b0, bus.imem_addr}, 32'd255);

    // Not-taken BEQZ at pc 254 falls through to 255.
    do_reset();
    issue(9'b100_10_0101, 0);   // LI R2,5
    while (mpc != 8'd254) issue(NOP, 0);
    issue(9'b101_10_0011, 0);   // BEQZ R2,+3
    wait_fetch();
    chk("beqz_fall", {24'b0, bus.imem_addr}, 32'd255);

    // HALT parks the sequencer; fetch pulses are ignored.
    issue(HALT, 0);
    tick();
    chk("halt_halted", {31'b0, bus.halted}, 32'd1);
    chk("halt_req", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_valid = 1'b1;
      bus.imem_data  = 9'b100_00_0001;
      tick();
      bus.imem_valid = 1'b0;
      chk("halt_stays", {31'b0, bus.halted}, 32'd1);
      chk("halt_pc", {24'b0, bus.imem_addr}, {24'b0, mpc});
    end
    do_reset();
    chk("unhalt", {31'b0, bus.halted}, 32'd0);

    // Reset during WRITEBACK of ADD suppresses the write.
    issue(9'b100_01_0010, 0);   // LI R1,2
    issue(9'b100_10_0010, 0);   // LI R2,2
    wait_fetch();
    mon_en = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_data  = 9'b000_11_01_10;  // ADD R3,R1,R2
    tick();
    bus.imem_valid = 1'b0;
    tick();
    tick();
    chk("abort_wb_seen", {31'b0, bus.rf_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", {31'b0, bus.rf_wr_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    chk("abort_r3", {23'b0, rf[3]}, {23'b0, mdl[3]});
    chk("abort_pc", {24'b0, bus.imem_addr}, {24'b0, RST_PC});
    chk("abort_fetch", {31'b0, bus.imem_req}, 32'd1);
    mpc = RST_PC;
    last_ins = '0;

    // Normal operation resumes after the abort.
    issue(9'b100_00_0001, 0);   // LI R0,1
    wait_fetch();
    chk("resume_r0", {23'b0, rf[0]}, 32'h001);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer directly upstream of the 4 x 9-bit register file.
- Fetches 9-bit instructions from instruction memory through a valid handshake, decodes them, and drives the register-file read/write ports.
- Sequences operands through the external combinational ALU and writes results back.
- Owns the program counter and the halt state.

Parameters:
- PC_W, 8, program-counter / instruction-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction request; high only in FETCH.
- imem_addr  out  PC_W  current PC.
- imem_valid  in  1  imem_data valid this cycle.
- imem_data  in  9  instruction word.
- rf_rd0_addr  out  2  register-file read port 0 address.
- rf_rd1_addr  out  2  register-file read port 1 address.
- rf_rd0_data  in  9  signed, read port 0 data.
- rf_rd1_data  in  9  signed, read port 1 data.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  2  register-file write address.
- rf_wr_data  out  9  signed, write data.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- alu_a  out  9  ALU operand A (latched).
- alu_b  out  9  ALU operand B (latched).
- alu_result  in  9  combinational ALU result, 9-bit two's-complement wrap.
- halted  out  1  high while in HALT.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: pc=RESET_PC, IR=0, A=B=0, result=0, state=FETCH, rf_wr_en=0, halted=0, imem_req=0 during the reset cycle.
- Reset has priority over all events. A reset asserted in any state, including WRITEBACK, suppresses rf_wr_en that cycle and aborts the instruction.
- Instruction format: [8:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
  - imm4 = IR[3:0], sign-extended to 9 bits (range -8..7).
- Opcodes:
  - 000 ADD: R[rd] = R[rs] + R[rt]
  - 001 SUB: R[rd] = R[rs] - R[rt]
  - 010 AND: R[rd] = R[rs] & R[rt]
  - 011 OR: R[rd] = R[rs] | R[rt]
  - 100 LI: R[rd] = sext(imm4)
  - 101 BEQZ: if R[rd]==0 then pc = pc + sext(imm4)
  - 110 NOP
  - 111 HALT
- Read addresses, combinational from IR: rf_rd0_addr = (op==BEQZ) ? rd : rs; rf_rd1_addr = rt.
- Write outputs:
  - rf_wr_addr = rd.
  - rf_wr_data = (op==LI) ? sext(imm4) : result register.
- alu_op = op[1:0]. alu_a / alu_b come from the A/B registers.
- FETCH:
  - imem_req=1.
  - Stay while imem_valid=0 (unbounded stall, no timeout).
  - On imem_valid=1: IR<=imem_data, pc<=pc+1 (mod 2^PC_W), go to DECODE.
- DECODE:
  - A<=rf_rd0_data, B<=rf_rd1_data.
  - Next state: ALU ops -> EXECUTE; LI -> WRITEBACK; BEQZ -> EXECUTE; NOP -> FETCH; HALT -> HALT.
- EXECUTE:
  - ALU ops: result<=alu_result, go to WRITEBACK.
  - BEQZ: if A==0, pc<=pc+sext(imm4) (pc already incremented, so target = branch_addr+1+imm4), computed mod 2^PC_W. Go to FETCH.
- WRITEBACK: rf_wr_en=1 for exactly this one cycle; go to FETCH.
- HALT: halted=1, imem_req=0, rf_wr_en=0. Leave only on rst.
- rf_wr_en is high only in WRITEBACK, never in any other state.
- Latency with zero fetch wait:
  - ALU op: 4 cycles.
  - LI: 3 cycles.
  - BEQZ: 3 cycles.
  - NOP: 2 cycles.
  - Each fetch wait cycle adds 1.
- Arithmetic: overflow wraps in the ALU, with no flags. PC wraps from 2^PC_W-1 to 0.
- Same-register read/write (e.g. ADD R1,R1,R1): operands are latched in DECODE before WRITEBACK, so no hazard exists.

Test Plan:
- Reset, then stream LI R1,3; LI R2,-2; ADD R3,R1,R2 with imem_valid=1 every fetch -> writes R1=3 (cycle 3), R2=0x1FE (cycle 6), R3=1 (cycle 10); rf_wr_en high exactly 3 cycles total.
- LI R0,7; LI R1,7; SUB R2,R0,R1 then OR R3,R0,R1 -> R2=0, R3=7; alu_op observed 01 then 11.
- imem_valid held low 5 cycles during FETCH -> state, pc and IR unchanged, imem_req held high, no writes; instruction completes normally once valid rises.
- BEQZ at pc=254 with PC_W=8, R[rd]=0, imm4=+3 -> next imem_addr=2 (wrap). Same instruction with R[rd]=5 -> next imem_addr=255.
- HALT fetched -> halted=1 from the following cycle, imem_req=0; further imem_valid pulses ignored. Then rst -> halted=0, imem_addr=RESET_PC.
- rst asserted during WRITEBACK of ADD -> rf_wr_en=0 that cycle, no register write, state=FETCH and pc=RESET_PC next cycle.
